counter_b4_event_fifo: RTL
==========================

// Module: counter_b4_event_fifo
// PURPOSE
//  Downstream stage of the 4-bit counter: watches b4_Q/b4_rco/b4_load/b4_mode and logs each
//  rollover (rco rising edge) and load event into a small FIFO as a tagged event word.
//  A consumer such as the checker or a log writer drains it over a valid/ready handshake.
//  Overflow is reported, never silently hidden.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >=2
//  TS_W    8   timestamp width (free-running cycle counter, wraps)
//  DROP_W  8   width of the saturating dropped-event counter
// PORTS
//  b4_clk       in   1        clock, all logic on posedge
//  b4_reset_n   in   1        asynchronous active-low reset
//  b4_Q         in   4        counter value
//  b4_rco       in   1        counter ripple-carry-out
//  b4_load      in   1        counter load indication
//  b4_mode      in   2        counter mode (00/01/10/11)
//  b4_clear     in   1        sync clear: flush FIFO, clear overflow and drop count
//  ev_ready     in   1        consumer accepts head entry
//  ev_valid     out  1        head entry valid (FIFO not empty)
//  ev_data      out  EV_W     {type[1:0], mode[1:0], Q[3:0] [, ts[TS_W-1:0]]}
//  ev_count     out  log2(DEPTH)+1  entries held
//  ev_overflow  out  1        sticky: an event was dropped
//  ev_drops     out  DROP_W   dropped events, saturates at all-ones
// BEHAVIOUR
//  Reset: ev_valid=0, ev_count=0, ev_overflow=0, ev_drops=0, ev_data=0, rco_d=0, ts=0.
//  Detection: rco_rise = b4_rco & ~rco_d (rco_d = b4_rco registered); load_ev = b4_load.
//   type: 01 rco only, 10 load only, 11 both in same cycle (one entry), 00 never written.
//   Q/mode/ts are those sampled at the same edge as the event.
//  Push at the detecting edge; ev_valid rises after that edge (1-cycle latency). No bypass.
//  Output is show-ahead: ev_data = head while ev_valid; pop when ev_valid & ev_ready.
//  Push+pop same cycle: both happen, count unchanged; legal at full (slot freed) and
//   at count=1.
//  Full and push without pop: event dropped, ev_overflow<=1, ev_drops+1 (saturating).
//  Pop while empty: ignored (ev_valid=0 makes it impossible by handshake).
//  Pointers wrap modulo DEPTH; count tracks 0..DEPTH inclusive.
//  ts increments every cycle, wraps 2^TS_W-1 -> 0.
//  b4_clear: highest priority; count=0, overflow/drops cleared, any same-cycle push and pop
//   discarded; rco_d and ts continue.
//  Reset mid-operation: all state returns to reset values immediately (asynchronous).
// CONFIGURATION
//  CB4_EVT_TIMESTAMP_EN defined: ts field appended, EV_W = 8+TS_W.
//  Not defined: no timestamp counter, EV_W = 8, ev_data = {type, mode, Q}; TS_W unused.
// STRUCTURE
//  Package counter_b4_evt_pkg: EVT_NONE/EVT_RCO/EVT_LOAD/EVT_BOTH type codes, field
//   widths and bit offsets, EV_W helper.
//  One sub-module: cb4_sync_fifo (generic WIDTH/DEPTH, show-ahead, push/pop/clear, full/
//   empty/count). Top holds detection, timestamp, overflow/drop logic.
// TESTING
//  1 Reset: hold b4_reset_n=0 mid-stream -> all outputs 0 same cycle; release, no spurious
//    event.
//  2 rco 0->1 with Q=4'hF, mode=2'b00, ready=0 -> one entry {01,00,F}, ev_valid next cycle;
//    rco held high 3 cycles -> still one entry.
//  3 b4_load=1 and rco rise same edge, Q=4'hA, mode=2'b11 -> single entry type 11, Q=A.
//  4 ready=0, 10 events into DEPTH=8 -> count=8, ev_overflow=1, ev_drops=2; drain in order,
//    first 8 events intact.
//  5 Full FIFO, ready=1 and new event same cycle -> count stays 8, no drop, new event at tail.
//  6 b4_clear with push and pop asserted -> count=0, ev_valid=0, drops=0 next cycle;
//    with macro, ts continues from previous value.

Source files
------------

// File: rtl/counter_b4_evt_pkg.sv
// Shared definitions for the counter_b4 event logger: event type codes,
// event word field widths and offsets, and the event word width helper.
// Build option: CB4_EVT_TIMESTAMP_EN appends a TS_W-bit timestamp to each word.
package counter_b4_evt_pkg;

   // Event type codes (EVT_NONE is never written into the FIFO)
   localparam logic [1:0] EVT_NONE = 2'b00;
   localparam logic [1:0] EVT_RCO  = 2'b01;
   localparam logic [1:0] EVT_LOAD = 2'b10;
   localparam logic [1:0] EVT_BOTH = 2'b11;

   // Base event word layout: {type, mode, Q}
   localparam int unsigned TYPE_W   = 2;
   localparam int unsigned MODE_W   = 2;
   localparam int unsigned Q_W      = 4;
   localparam int unsigned BASE_W   = TYPE_W + MODE_W + Q_W;
   localparam int unsigned Q_LSB    = 0;
   localparam int unsigned MODE_LSB = Q_LSB + Q_W;
   localparam int unsigned TYPE_LSB = MODE_LSB + MODE_W;

`ifdef CB4_EVT_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   // Event word width; the base fields sit above the optional timestamp
   function automatic int unsigned ev_w(input int unsigned ts_w);
      return TS_EN ? (BASE_W + ts_w) : BASE_W;
   endfunction

endpackage

// File: rtl/cb4_sync_fifo.sv
// Generic synchronous show-ahead FIFO with registered head word.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear            synchronous flush, overrides push and pop
//   push, din        write request and data (ignored when full unless popping)
//   pop              read request (ignored when empty)
//   dout, valid      registered head word and non-empty flag (dout=0 when empty)
//   count            entries held, 0..DEPTH
//   full_c           combinational full flag derived from count
module cb4_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_next;
   logic [CW-1:0]    remaining;
   logic [CW-1:0]    cnt_next;
   logic [WIDTH-1:0] head_next;
   logic             do_push;
   logic             do_pop;

   assign full_c = (count == CW'(DEPTH));

   // Next-state: a pop at full frees the slot the same-cycle push reuses.
   // The head register is loaded from din when no older entry survives.
   always_comb begin
      do_pop    = pop & valid;
      do_push   = push & (~full_c | do_pop);
      rd_next   = rd_ptr + AW'(do_pop);
      remaining = count - CW'(do_pop);
      cnt_next  = remaining + CW'(do_push);
      head_next = '0;
      if (cnt_next != '0) begin
         head_next = (remaining == '0) ? din : mem[rd_next];
      end
   end

   // Pointer, count and head registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         dout   <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         dout   <= '0;
      end else begin
         rd_ptr <= rd_next;
         wr_ptr <= wr_ptr + AW'(do_push);
         count  <= cnt_next;
         valid  <= (cnt_next != '0);
         dout   <= head_next;
      end
   end

   // Storage array
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/counter_b4_event_fifo.sv
// Event logger for the 4-bit counter: records each rco rising edge and each
// load as a tagged word in a FIFO drained over a valid/ready handshake.
// Build option: CB4_EVT_TIMESTAMP_EN adds a free-running TS_W-bit timestamp.
// Ports:
//   b4_clk, b4_reset_n   clock, asynchronous active-low reset
//   b4_Q, b4_rco         counter value and ripple-carry-out
//   b4_load, b4_mode     counter load indication and mode
//   b4_clear             sync flush of FIFO, overflow flag and drop count
//   ev_ready             consumer accepts head entry
//   ev_valid, ev_data    head entry valid and word {type, mode, Q [, ts]}
//   ev_count             entries held
//   ev_overflow          sticky: an event was dropped
//   ev_drops             saturating dropped-event count
module counter_b4_event_fifo
   import counter_b4_evt_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned TS_W   = 8,
   parameter int unsigned DROP_W = 8
) (
   input  logic                       b4_clk,
   input  logic                       b4_reset_n,
   input  logic [3:0]                 b4_Q,
   input  logic                       b4_rco,
   input  logic                       b4_load,
   input  logic [1:0]                 b4_mode,
   input  logic                       b4_clear,
   input  logic                       ev_ready,
   output logic                       ev_valid,
   output logic [ev_w(TS_W)-1:0]      ev_data,
   output logic [$clog2(DEPTH):0]     ev_count,
   output logic                       ev_overflow,
   output logic [DROP_W-1:0]          ev_drops
);

   localparam int unsigned EV_W = ev_w(TS_W);

   logic            rco_d;
   logic            rco_rise;
   logic [1:0]      ev_type;
   logic            push;
   logic            pop;
   logic            drop;
   logic            fifo_full;
   logic [EV_W-1:0] ev_word;

   // Event detection: rco edge and load may coincide and share one entry
   assign rco_rise = b4_rco & ~rco_d;
   assign ev_type  = {b4_load, rco_rise};
   assign push     = (ev_type != EVT_NONE);
   assign pop      = ev_valid & ev_ready;
   assign drop     = push & fifo_full & ~pop & ~b4_clear;

   // rco history keeps running through b4_clear
   always_ff @(posedge b4_clk or negedge b4_reset_n) begin
      if (!b4_reset_n) begin
         rco_d <= 1'b0;
      end else begin
         rco_d <= b4_rco;
      end
   end

`ifdef CB4_EVT_TIMESTAMP_EN
   logic [TS_W-1:0] ts;

   // Free-running timestamp, unaffected by b4_clear
   always_ff @(posedge b4_clk or negedge b4_reset_n) begin
      if (!b4_reset_n) begin
         ts <= '0;
      end else begin
         ts <= ts + TS_W'(1);
      end
   end

   assign ev_word = {ev_type, b4_mode, b4_Q, ts};
`else
   assign ev_word = {ev_type, b4_mode, b4_Q};
`endif

   // Overflow flag and saturating drop counter
   always_ff @(posedge b4_clk or negedge b4_reset_n) begin
      if (!b4_reset_n) begin
         ev_overflow <= 1'b0;
         ev_drops    <= '0;
      end else if (b4_clear) begin
         ev_overflow <= 1'b0;
         ev_drops    <= '0;
      end else if (drop) begin
         ev_overflow <= 1'b1;
         if (ev_drops != '1) begin
            ev_drops <= ev_drops + DROP_W'(1);
         end
      end
   end

   cb4_sync_fifo #(
      .WIDTH (EV_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (b4_clk),
      .rst_n  (b4_reset_n),
      .clear  (b4_clear),
      .push   (push),
      .pop    (pop),
      .din    (ev_word),
      .dout   (ev_data),
      .valid  (ev_valid),
      .count  (ev_count),
      .full_c (fifo_full)
   );

endmodule
